wb_ram_initiator: RTL and testbench

- Wishbone classic initiator that turns a block command (start word, length, direction) into a sequence of single Wishbone transfers into the OpenRAM channel window.
- Sits between a local engine (test sequencer, loader, DMA front-end) and the user-area Wishbone bus, on the opposite end from the RAM channel controllers.
- Streams write data in and read data out with valid/ready handshakes.
- Enforces the stb gap and single-outstanding rules that the RAM channels require.

---
 rtl/wb_ram_initiator_if.sv | 21 ++
 rtl/wb_ram_initiator.sv | 180 ++++++++++++++++++
 tb/tb_wb_ram_initiator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_initiator_if.sv
// Wishbone classic bus between the block initiator and the OpenRAM channel window.
interface wb_ram_initiator_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_ram_initiator.sv
// Block-command Wishbone initiator: splits a (start word, length, direction) command
// into single classic transfers, one outstanding, with a one-cycle stb gap between them.
module wb_ram_initiator #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ADDR_WIDTH = 8,
    parameter int          LEN_WIDTH  = 8,
    parameter int          TIMEOUT    = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    // Every stream below uses plain valid/ready: a word moves on a rising edge where
    // both are high; the producer keeps valid and data stable until that edge.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-3:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [31:0]           wdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state,
    wb_ram_initiator_if.master    wbm
);
    localparam int OW = ADDR_WIDTH - 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]           state;
    logic [2:0]           state_n;
    logic                 we_r;
    logic [OW-1:0]        off;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] idx;
    logic [LEN_WIDTH-1:0] idx_inc;
    logic [7:0]           tmo_cnt;
    logic                 tmo_hit;
    logic [31:0]          rdata_r;
    logic                 err_r;
    logic                 start_req;
    logic                 start_we;
    logic                 end_req;
    logic [OW-1:0]        req_off;

    // Word offset wraps inside the window; nothing carries into BASE_ADDR.
    function automatic logic [31:0] word_adr(input logic [OW-1:0] o);
        logic [31:0] byte_off;
        byte_off = '0;
        byte_off[ADDR_WIDTH-1:0] = {o, 2'b00};
        return BASE_ADDR | byte_off;
    endfunction

    assign idx_inc = idx + LEN_WIDTH'(1);
    assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_n   = state;
        start_req = 1'b0;
        start_we  = (state == S_IDLE) ? cmd_we : we_r;
        end_req   = 1'b0;
        req_off   = off;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_n = S_DONE;
                    end else if (cmd_we) begin
                        state_n = S_FETCH;
                    end else begin
                        state_n   = S_REQ;
                        start_req = 1'b1;
                        req_off   = cmd_addr;
                    end
                end
            end
            S_FETCH: begin
                if (wdata_valid) begin
                    state_n   = S_REQ;
                    start_req = 1'b1;
                end
            end
            S_REQ: begin
                // An ack on the expiry cycle still completes the transfer.
                if (wbm.wbm_ack_i) begin
                    state_n = we_r ? S_GAP : S_RESP;
                    end_req = 1'b1;
                end else if (tmo_hit) begin
                    state_n = S_DONE;
                    end_req = 1'b1;
                end
            end
            S_RESP: begin
                if (rdata_ready) state_n = S_GAP;
            end
            S_GAP: begin
                if (idx_inc == len_r) begin
                    state_n = S_DONE;
                end else if (we_r) begin
                    state_n = S_FETCH;
                end else begin
                    state_n   = S_REQ;
                    start_req = 1'b1;
                    req_off   = off + OW'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state         <= S_IDLE;
            we_r          <= 1'b0;
            off           <= '0;
            len_r         <= '0;
            idx           <= '0;
            tmo_cnt       <= '0;
            rdata_r       <= '0;
            err_r         <= 1'b0;
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_sel_o <= 4'h0;
            wbm.wbm_adr_o <= '0;
            wbm.wbm_dat_o <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && cmd_valid) begin
                we_r  <= cmd_we;
                off   <= cmd_addr;
                len_r <= cmd_len;
                idx   <= '0;
                err_r <= 1'b0;
            end
            if (state == S_FETCH && wdata_valid) wbm.wbm_dat_o <= wdata;
            if (state == S_GAP) begin
                idx <= idx_inc;
                off <= off + OW'(1);
            end
            if (state == S_REQ && wbm.wbm_ack_i && !we_r) rdata_r <= wbm.wbm_dat_i;
            if (state == S_REQ && !wbm.wbm_ack_i && tmo_hit) err_r <= 1'b1;

            if (start_req) tmo_cnt <= '0;
            else if (state == S_REQ) tmo_cnt <= tmo_cnt + 8'd1;

            if (start_req) begin
                wbm.wbm_cyc_o <= 1'b1;
                wbm.wbm_stb_o <= 1'b1;
                wbm.wbm_we_o  <= start_we;
                wbm.wbm_sel_o <= 4'hF;
                wbm.wbm_adr_o <= word_adr(req_off);
            end else if (end_req) begin
                wbm.wbm_cyc_o <= 1'b0;
                wbm.wbm_stb_o <= 1'b0;
                wbm.wbm_we_o  <= 1'b0;
                wbm.wbm_sel_o <= 4'h0;
            end
        end
    end

    assign cmd_ready   = (state == S_IDLE);
    assign wdata_ready = (state == S_FETCH);
    assign rdata_valid = (state == S_RESP);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign err         = err_r;
    assign rdata       = rdata_r;
    assign dbg_state   = state;
endmodule

// File: tb/tb_wb_ram_initiator.sv
// Directed plus random block commands against a word-level reference of the RAM window,
// with a Wishbone slave of programmable ack latency.
module tb_wb_ram_initiator;
    localparam int          TMO  = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        busy, done, err;
    logic [2:0]  dbg_state;

    wb_ram_initiator_if bus ();

    wb_ram_initiator #(.TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state),
        .wbm(bus.master)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] slave_mem [64];
    logic        mem_init;
    logic        slave_en;
    int          slave_delay;
    int          wait_cnt;

    // Slave: acks slave_delay cycles after it first sees stb, holds ack one cycle.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) slave_mem[i] <= ref_mem[i];
        end
        if (!rst_n) begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_dat_i <= '0;
            wait_cnt      <= 0;
        end else if (bus.wbm_ack_i) begin
            bus.wbm_ack_i <= 1'b0;
            wait_cnt      <= 0;
        end else if (bus.wbm_cyc_o && bus.wbm_stb_o && slave_en) begin
            if (wait_cnt == slave_delay) begin
                bus.wbm_ack_i <= 1'b1;
                wait_cnt      <= 0;
                if (bus.wbm_we_o) slave_mem[bus.wbm_adr_o[7:2]] <= bus.wbm_dat_o;
                else              bus.wbm_dat_i <= slave_mem[bus.wbm_adr_o[7:2]];
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge with the DUT idle.
    task automatic run_cmd(input bit we, input logic [5:0] addr, input logic [7:0] len,
                           input int wstall_word, input int rstall_word, input int stall_len,
                           input bit hold_valid, input bit expect_tmo, input bit fixed_data);
        logic [31:0] wq[$];
        logic [31:0] rq[$];
        logic [68:0] exp_q[$];
        logic [68:0] obs_q[$];
        logic [5:0]  o;
        logic [31:0] d;
        int widx = 0, ridx = 0, wstall_cnt = 0, rstall_cnt = 0, cycles = 0;
        int stb_run = 0, max_run = 0, stb_rises = 0;
        bit prev_wready = 0, prev_rvalid = 0, prev_ack = 0, prev_stb = 0, done_seen = 0;

        for (int i = 0; i < int'(len); i++) begin
            o = 6'(int'(addr) + i);
            if (we) begin
                d = fixed_data ? 32'hA5A5_0000 + 32'(i + 1) : $urandom;
                wq.push_back(d);
                exp_q.push_back({1'b1, 4'hF, BASE | {24'h0, o, 2'b00}, d});
                ref_mem[o] = d;
            end else begin
                rq.push_back(ref_mem[o]);
                exp_q.push_back({1'b0, 4'hF, BASE | {24'h0, o, 2'b00}, ref_mem[o]});
            end
        end
        if (expect_tmo) exp_q.delete();

        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
        wdata_valid = 1'b0; rdata_ready = 1'b0;
        while (!done_seen && cycles < 600) begin
            @(negedge clk);
            cycles++;
            if (prev_wready && wdata_valid) begin
                widx++;
                check("wr_start", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b11);
            end
            if (prev_rvalid && rdata_ready) ridx++;
            if (prev_ack) check("gap", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_sel_o}, 6'h0);
            if (bus.wbm_stb_o && bus.wbm_ack_i)
                obs_q.push_back({bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
                                 bus.wbm_we_o ? bus.wbm_dat_o : bus.wbm_dat_i});
            if (bus.wbm_stb_o) begin
                if (!prev_stb) stb_rises++;
                stb_run++;
            end else if (prev_stb) begin
                if (stb_run > max_run) max_run = stb_run;
                stb_run = 0;
            end
            if (cycles == 1) begin
                check("accept_busy", busy, 1'b1);
                check("err_cleared", err, 1'b0);
                if (len == 0) check("zero_done", done, 1'b1);
                if (!hold_valid) cmd_valid = 1'b0;
            end
            if (hold_valid) check("busy_ready", cmd_ready, 1'b0);
            if (wdata_ready && widx == wstall_word && wstall_cnt < stall_len) begin
                check("wstall_bus", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b00);
                wstall_cnt++;
            end
            if (rdata_valid) begin
                if (ridx < rq.size()) check("rdata", rdata, rq[ridx]);
                check("rd_nostb", bus.wbm_stb_o, 1'b0);
                if (ridx == rstall_word && rstall_cnt < stall_len) begin
                    rdata_ready = 1'b0;
                    rstall_cnt++;
                end else begin
                    rdata_ready = 1'b1;
                end
            end else begin
                rdata_ready = 1'b0;
            end
            if (done) begin
                done_seen = 1;
                check("err_at_done", err, expect_tmo);
                cmd_valid = 1'b0;
            end
            if (we && widx < wq.size() && !(widx == wstall_word && wstall_cnt < stall_len)) begin
                wdata_valid = 1'b1;
                wdata = wq[widx];
            end else begin
                wdata_valid = 1'b0;
            end
            prev_wready = wdata_ready;
            prev_rvalid = rdata_valid;
            prev_ack    = bus.wbm_stb_o && bus.wbm_ack_i;
            prev_stb    = bus.wbm_stb_o;
        end
        check("done_seen", done_seen, 1'b1);
        wdata_valid = 1'b0; rdata_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", {done, busy, cmd_ready}, 3'b001);
        check("n_xfers", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check("xfer", obs_q[i], exp_q[i]);
        if (expect_tmo) begin
            check("tmo_stb_len", max_run, TMO);
            check("tmo_one_addr", stb_rises, 1);
        end else begin
            check("stb_per_word", stb_rises, int'(len));
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_init = 1'b1; slave_en = 1'b1; slave_delay = 2;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        check("rst_ctrl", {cmd_ready, busy, done, err, wdata_ready, rdata_valid,
                           bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, 13'h1000);
        check("rst_data", {bus.wbm_adr_o, bus.wbm_dat_o}, 64'h0);
        check("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write burst, ack two cycles after stb.
        slave_delay = 2;
        run_cmd(1'b1, 6'h02, 8'd3, -1, -1, 0, 1'b0, 1'b0, 1'b1);
        // Read burst wrapping past the top of the window, consumer stalls on word 1.
        slave_delay = 1;
        run_cmd(1'b0, 6'h3E, 8'd4, -1, 1, 5, 1'b0, 1'b0, 1'b0);
        // Read with no ack at all.
        slave_en = 1'b0;
        run_cmd(1'b0, 6'($urandom_range(0, 63)), 8'd2, -1, -1, 0, 1'b0, 1'b1, 1'b0);
        slave_en = 1'b1;
        // Zero length, also clears the sticky err.
        run_cmd(1'b1, 6'($urandom_range(0, 63)), 8'd0, -1, -1, 0, 1'b0, 1'b0, 1'b0);
        // cmd_valid held through a 3-word write.
        slave_delay = 0;
        run_cmd(1'b1, 6'($urandom_range(0, 63)), 8'd3, -1, -1, 0, 1'b1, 1'b0, 1'b0);
        // Producer stalls 4 cycles before the second write word.
        run_cmd(1'b1, 6'($urandom_range(0, 63)), 8'd3, 1, -1, 4, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            int len_r;
            len_r = $urandom_range(1, 8);
            slave_delay = $urandom_range(0, 3);
            run_cmd(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'(len_r),
                    $urandom_range(0, len_r - 1), $urandom_range(0, len_r - 1),
                    $urandom_range(0, 3), 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset while a request is on the bus.
        slave_en = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 6'($urandom_range(0, 63)); cmd_len = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_rst_stb", bus.wbm_stb_o, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_rst", {bus.wbm_cyc_o, bus.wbm_stb_o, busy}, 3'b000);
        repeat (2) @(negedge clk);
        check("rst_no_done", done, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", {cmd_ready, done, bus.wbm_cyc_o}, 3'b100);
        end
        slave_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
